// File: rtl/pixel_clock_nco.sv
// pixel_clock_nco: phase-accumulator NCO producing a pixel clock, a per-period enable and a lock flag
module pixel_clock_nco #(
    parameter int               ACC_W       = 16,
    parameter int               NUM_MODES   = 4,
    parameter logic [ACC_W-1:0] INC_0       = 16'h4000,
    parameter logic [ACC_W-1:0] INC_1       = 16'h6666,
    parameter logic [ACC_W-1:0] INC_2       = 16'h8000,
    parameter logic [ACC_W-1:0] INC_3       = 16'h2000,
    parameter int               LOCK_CYCLES = 16
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] mode_sel,
    output logic       pixel_clk,
    output logic       pixel_ce,
    output logic       locked,
    output logic [1:0] active_mode,
    output logic       mode_err
);
    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;
    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] new_inc;
    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] lock_cnt;
    logic [1:0]       eff_mode;
    logic             illegal;
    logic             lock_done;
    assign pixel_clk = acc[ACC_W-1];
    // Out-of-range presets fall back to mode 0; the accumulator sum carries the wrap bit
    always_comb begin
        illegal   = int'(mode_sel) >= NUM_MODES;
        eff_mode  = illegal ? 2'd0 : mode_sel;
        new_inc   = eff_mode == 2'd0 ? INC_0 :
                    eff_mode == 2'd1 ? INC_1 :
                    eff_mode == 2'd2 ? INC_2 : INC_3;
        sum       = {1'b0, acc} + {1'b0, inc};
        lock_done = lock_cnt == CNT_W'(LOCK_CYCLES - 1);
    end
    // Control FSM and NCO datapath: stop on en low, (re)enter SETTLE on start or rate change, else run
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            inc         <= '0;
            lock_cnt    <= '0;
            pixel_ce    <= 1'b0;
            locked      <= 1'b0;
            active_mode <= 2'd0;
            mode_err    <= 1'b0;
        end else begin
            if (en && illegal)
                mode_err <= 1'b1;
            if (!en) begin
                state    <= IDLE;
                acc      <= '0;
                lock_cnt <= '0;
                pixel_ce <= 1'b0;
                locked   <= 1'b0;
            end else if (state == IDLE || eff_mode != active_mode) begin
                state       <= SETTLE;
                acc         <= '0;
                inc         <= new_inc;
                active_mode <= eff_mode;
                lock_cnt    <= '0;
                pixel_ce    <= 1'b0;
                locked      <= 1'b0;
            end else begin
                acc      <= sum[ACC_W-1:0];
                pixel_ce <= sum[ACC_W];
                if (state == SETTLE) begin
                    lock_cnt <= lock_cnt + 1'b1;
                    if (lock_done) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
